zigzag_buffer: RTL and testbench

//  Ping-pong 8x8 coefficient buffer that sits directly downstream of the DCT
//  (u,v) sequencer. Accepts one coefficient per cycle tagged with its (u,v)

---
 rtl/codec_pkg.sv | 19 +
 rtl/ff_en.sv | 20 ++
 rtl/zigzag_lut.sv | 13 +
 rtl/zigzag_buffer.sv | 104 ++++++++++
 tb/tb_zigzag_buffer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/codec_pkg.sv
// Shared block-transform constants and the JPEG zig-zag scan table
// (zig-zag position -> raster address), also used by the inverse stage.
package codec_pkg;

    localparam int unsigned BLK_DIM = 8;
    localparam int unsigned BLK_SZ  = BLK_DIM * BLK_DIM;

    localparam logic [5:0] ZZ_ORDER [BLK_SZ] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/ff_en.sv
// Enabled register with synchronous active-low reset to a fixed value.
module ff_en #(
    parameter int unsigned W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/zigzag_lut.sv
// Combinational zig-zag position to raster address lookup.
module zigzag_lut
    import codec_pkg::*;
(
    input  logic [5:0] idx,
    output logic [5:0] addr
);

    always_comb begin
        addr = ZZ_ORDER[idx];
    end

endmodule

// File: rtl/zigzag_buffer.sv
// Ping-pong 8x8 coefficient buffer: raster-indexed writes in any order,
// replay of each completed block in zig-zag order over valid/ready.
module zigzag_buffer
    import codec_pkg::*;
#(
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [2:0]        in_u,
    input  logic [2:0]        in_v,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_idx,
    output logic              out_last,
    input  logic              out_ready
);

    logic [DATA_W-1:0] mem [2*BLK_SZ];

    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    logic [5:0] rd_k;
    logic [5:0] rd_addr;

    logic       wr_fire;
    logic       closing;
    logic       rd_fire;
    logic       rd_done;
    logic [1:0] full_set;
    logic [1:0] full_clr;

    always_comb begin
        in_ready  = !full[wr_bank];
        wr_fire   = in_valid & in_ready;
        closing   = wr_fire & (in_u == 3'd7) & (in_v == 3'd7);
        out_valid = full[rd_bank];
        rd_fire   = out_valid & out_ready;
        rd_done   = rd_fire & (rd_k == 6'd63);
        out_idx   = rd_k;
        out_last  = out_valid & (rd_k == 6'd63);
        out_data  = mem[{rd_bank, rd_addr}];
    end

    // A bank being closed is never full and a bank being drained is always
    // full, so set and clear can never target the same flag in one cycle.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            full_set[b] = closing & (wr_bank == b[0]);
            full_clr[b] = rd_done & (rd_bank == b[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[{wr_bank, in_u, in_v}] <= in_data;
    end

    zigzag_lut u_lut (
        .idx  (rd_k),
        .addr (rd_addr)
    );

    for (genvar g = 0; g < 2; g++) begin : g_full
        ff_en #(.W(1), .RST_VAL(1'b0)) u_full (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (full_set[g] | full_clr[g]),
            .d     (full_set[g]),
            .q     (full[g])
        );
    end

    ff_en #(.W(1), .RST_VAL(1'b0)) u_wr_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (closing),
        .d     (~wr_bank),
        .q     (wr_bank)
    );

    ff_en #(.W(1), .RST_VAL(1'b0)) u_rd_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_done),
        .d     (~rd_bank),
        .q     (rd_bank)
    );

    ff_en #(.W(6), .RST_VAL(6'd0)) u_rd_k (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_fire),
        .d     (rd_k + 6'd1),
        .q     (rd_k)
    );

endmodule

// File: tb/tb_zigzag_buffer.sv
// Directed bench for zigzag_buffer: fill/replay, latency, back-pressure,
// ping-pong, out-of-order writes and mid-block reset.
module tb_zigzag_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_u;
    logic [2:0]  in_v;
    logic [11:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;

    // Hand-copied JPEG zig-zag scan (position -> raster address)
    int zz [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [11:0] exp_blk [64];

    zigzag_buffer #(.DATA_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_u      (in_u),
        .in_v      (in_v),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pat(input int blk, input int a);
        return 12'((blk * 64 + a) ^ 32'h800);
    endfunction

    task automatic write_word(input int a, input logic [11:0] d);
        in_valid = 1'b1;
        in_u     = 3'(a / 8);
        in_v     = 3'(a % 8);
        in_data  = d;
        check("wr_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic write_raster(input int blk);
        for (int a = 0; a < 64; a++)
            write_word(a, pat(blk, a));
    endtask

    task automatic fill_exp(input int blk);
        for (int k = 0; k < 64; k++)
            exp_blk[k] = pat(blk, zz[k]);
    endtask

    task automatic read_block(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_data"},  out_data, exp_blk[k]);
            check({tag, "_idx"},   out_idx, k);
            check({tag, "_last"},  out_last, (k == 63) ? 1 : 0);
            cycle();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int k;
        int wc;
        int rc;
        logic tog;
        logic wfire;
        logic rfire;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_u      = '0;
        in_v      = '0;
        in_data   = '0;
        out_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_idx",   out_idx, 0);
        check("rst_out_last",  out_last, 0);

        // Raster fill with data = address; no output before the closing write
        out_ready = 1'b1;
        for (int a = 0; a < 64; a++) begin
            check("lat_pre_valid", out_valid, 0);
            write_word(a, 12'(a));
        end
        check("lat_valid", out_valid, 1);
        check("lat_idx",   out_idx, 0);
        for (int j = 0; j < 64; j++)
            exp_blk[j] = 12'(zz[j]);
        read_block("raster");
        check("raster_empty", out_valid, 0);

        // Back-pressure with out_ready alternating 1,0,1,0
        write_raster(1);
        fill_exp(1);
        k   = 0;
        tog = 1'b1;
        for (int c = 0; c < 300 && k < 64; c++) begin
            out_ready = tog;
            check("bp_valid", out_valid, 1);
            check("bp_data",  out_data, exp_blk[k]);
            check("bp_idx",   out_idx, k);
            check("bp_last",  out_last, (k == 63) ? 1 : 0);
            cycle();
            if (tog)
                k++;
            tog = ~tog;
        end
        out_ready = 1'b0;
        check("bp_count", k, 64);
        check("bp_empty", out_valid, 0);

        // Ping-pong: blocks A(2) and B(3) fill both banks, C(4) must wait
        write_raster(2);
        write_raster(3);
        check("pp_full_ready", in_ready, 0);
        in_valid = 1'b1;
        in_u     = 3'd7;
        in_v     = 3'd7;
        in_data  = 12'h123;
        cycle();
        check("pp_ignored_ready", in_ready, 0);
        wc = 0;
        rc = 0;
        for (int c = 0; c < 600 && rc < 192; c++) begin
            in_valid  = (wc < 64);
            in_u      = 3'(wc / 8);
            in_v      = 3'(wc % 8);
            in_data   = pat(4, wc);
            out_ready = 1'b1;
            if (rc < 64)
                check("pp_hold_ready", in_ready, 0);
            check("pp_valid", out_valid, 1);
            check("pp_data",  out_data, pat(2 + rc / 64, zz[rc % 64]));
            check("pp_idx",   out_idx, rc % 64);
            wfire = in_valid & in_ready;
            rfire = out_valid;
            cycle();
            if (wfire)
                wc++;
            if (rfire)
                rc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pp_reads",  rc, 192);
        check("pp_writes", wc, 64);
        check("pp_empty",  out_valid, 0);
        check("pp_ready",  in_ready, 1);

        // (7,7) first: bank closes at once over stale block B contents
        write_word(63, 12'h5A5);
        check("rev_valid", out_valid, 1);
        fill_exp(3);
        exp_blk[63] = 12'h5A5;
        read_block("stale");

        // Scrambled order ending with (7,7)
        for (int i = 0; i < 63; i++)
            write_word((i * 37 + 5) % 63, pat(6, (i * 37 + 5) % 63));
        check("scr_pre_valid", out_valid, 0);
        write_word(63, pat(6, 63));
        fill_exp(6);
        read_block("scram");

        // Reset mid-block: 30 writes to one bank, 10 reads from the other
        write_raster(7);
        for (int i = 0; i < 30; i++) begin
            out_ready = (i < 10);
            write_word(i, pat(8, i));
        end
        out_ready = 1'b0;
        check("mid_idx", out_idx, 10);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("rst2_out_valid", out_valid, 0);
        check("rst2_in_ready",  in_ready, 1);
        check("rst2_out_idx",   out_idx, 0);
        check("rst2_out_last",  out_last, 0);
        write_raster(9);
        fill_exp(9);
        read_block("fresh");
        check("fresh_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
